// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared iomem bus.
// One access at a time: IDLE grants, BUS holds the request, RESP returns the response.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     resp_q, resp_d;
  logic            rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic            pick;
  logic            done;
  logic            timeout;

  // On a tie the port that did not win last time is served; otherwise the lone requester.
  assign pick = (m0_valid_i && m1_valid_i) ? ~last_grant_q : m1_valid_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_d       = resp_q;
    rdy0_d       = 1'b0;
    rdy1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    done         = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = pick ? m1_addr_i  : m0_addr_i;
          wdata_d      = pick ? m1_wdata_i : m0_wdata_i;
          wstrb_d      = pick ? m1_wstrb_i : m0_wstrb_i;
          cnt_d        = '0;
          valid_d      = 1'b1;
          state_d      = S_BUS;
        end
      end
      S_BUS: begin
        // Ready wins over a timeout landing in the same cycle.
        if (iomem_ready) begin
          resp_d = iomem_rdata;
          done   = 1'b1;
        end else if (cnt_q == CntLast) begin
          resp_d  = ERR_RDATA;
          timeout = 1'b1;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (done) begin
          valid_d = 1'b0;
          rdy0_d  = ~grant_q;
          rdy1_d  = grant_q;
          err0_d  = ~grant_q & timeout;
          err1_d  = grant_q & timeout;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_q       <= '0;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_q       <= resp_d;
      rdy0_q       <= rdy0_d;
      rdy1_q       <= rdy1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign iomem_valid = valid_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign m0_ready_o  = rdy0_q;
  assign m1_ready_o  = rdy1_q;
  assign m0_err_o    = err0_q;
  assign m1_err_o    = err1_q;
  assign m0_rdata_o  = resp_q;
  assign m1_rdata_o  = resp_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Bench for iomem_arbiter: transaction-level model of grants, bus holding and responses.
module tb_iomem_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid, l_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        m0_ready, m0_err, m1_ready, m1_err, io_valid;
  logic [31:0] m0_rdata, m1_rdata, io_addr, io_wdata;
  logic [3:0]  io_wstrb;

  logic        l_m0_ready, l_m0_err, l_m1_ready, l_m1_err, l_io_valid;
  logic [31:0] l_m0_rdata, l_m1_rdata, l_io_addr, l_io_wdata;
  logic [3:0]  l_io_wstrb;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .iomem_valid(io_valid), .iomem_ready(bus_ready), .iomem_addr(io_addr),
    .iomem_wdata(io_wdata), .iomem_wstrb(io_wstrb), .iomem_rdata(bus_rdata)
  );

  // Default 64-cycle timeout instance, used only for the 17-cycle RAM read.
  iomem_arbiter u_dut_long (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_valid_i(l_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_ready_o(l_m0_ready), .m0_rdata_o(l_m0_rdata), .m0_err_o(l_m0_err),
    .m1_valid_i(1'b0), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_ready_o(l_m1_ready), .m1_rdata_o(l_m1_rdata), .m1_err_o(l_m1_err),
    .iomem_valid(l_io_valid), .iomem_ready(bus_ready), .iomem_addr(l_io_addr),
    .iomem_wdata(l_io_wdata), .iomem_wstrb(l_io_wstrb), .iomem_rdata(bus_rdata)
  );

  typedef struct {
    logic [1:0] req;
    int         lat_a;
    int         lat_b;
    int         exp_first;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payload();
    m0_addr  = $urandom;
    m0_wdata = $urandom;
    m0_wstrb = 4'($urandom);
    m1_addr  = $urandom;
    m1_wdata = $urandom;
    m1_wstrb = 4'($urandom);
  endtask

  // Called in an IDLE cycle; requesters in req hold valid until their ready pulse.
  // Bus answers the n-th grant on its lat-th BUS cycle (lat > TO means never).
  task automatic run_round(input logic [1:0] req, input int lat_a, input int lat_b,
                           output int first_port, output logic first_err);
    logic [1:0]  pend;
    int          p, lat, n;
    logic [31:0] ea, ew, rd, exp_rd;
    logic [3:0]  es;
    logic        tmo;
    pend = req;
    n = 0;
    first_port = -1;
    first_err = 1'b0;
    m0_valid = req[0];
    m1_valid = req[1];
    while (pend != 2'b00) begin
      p   = (pend == 2'b11) ? 1 - exp_last : (pend[1] ? 1 : 0);
      lat = (n == 0) ? lat_a : lat_b;
      ea  = (p == 1) ? m1_addr  : m0_addr;
      ew  = (p == 1) ? m1_wdata : m0_wdata;
      es  = (p == 1) ? m1_wstrb : m0_wstrb;
      rd  = $urandom;
      tmo = (lat > TO);
      exp_rd = tmo ? ERR : rd;
      cyc();
      for (int k = 1; k <= TO; k++) begin
        chk("bus_valid", 32'(io_valid), 32'd1);
        chk("bus_addr", io_addr, ea);
        chk("bus_wdata", io_wdata, ew);
        chk("bus_wstrb", 32'(io_wstrb), 32'(es));
        chk("no_early_ready", 32'({m1_ready, m0_ready}), 32'd0);
        if (p == 1) begin m1_addr = $urandom; m1_wdata = $urandom; end
        else begin m0_addr = $urandom; m0_wdata = $urandom; end
        if (k == lat) begin bus_ready = 1'b1; bus_rdata = rd; end
        cyc();
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        if (k == lat) break;
      end
      chk("resp_bus_idle", 32'(io_valid), 32'd0);
      chk("resp_ready", 32'({m1_ready, m0_ready}), (p == 1) ? 32'd2 : 32'd1);
      chk("resp_err", 32'({m1_err, m0_err}), tmo ? ((p == 1) ? 32'd2 : 32'd1) : 32'd0);
      chk("resp_rdata", (p == 1) ? m1_rdata : m0_rdata, exp_rd);
      if (n == 0) begin first_port = p; first_err = tmo; end
      exp_last = p;
      pend[p] = 1'b0;
      if (p == 1) m1_valid = 1'b0; else m0_valid = 1'b0;
      n++;
      cyc();
      chk("ready_one_cycle", 32'({m1_ready, m0_ready}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    int          fp;
    logic        fe;
    logic [1:0]  rq;

    vecs[0] = '{2'b01, 3, 0, 0, 1'b0};
    vecs[1] = '{2'b10, 2, 0, 1, 1'b0};
    vecs[2] = '{2'b11, 1, 1, 0, 1'b0};
    vecs[3] = '{2'b11, 4, 5, 0, 1'b0};
    vecs[4] = '{2'b01, 9, 0, 0, 1'b1};
    vecs[5] = '{2'b10, 8, 0, 1, 1'b0};
    vecs[6] = '{2'b11, 10, 1, 0, 1'b1};
    vecs[7] = '{2'b10, 1, 0, 1, 1'b0};

    rst_n = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; l_valid = 1'b0;
    bus_ready = 1'b0; bus_rdata = '0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    #12;
    chk("rst_bus_valid", 32'(io_valid), 32'd0);
    chk("rst_bus_addr", io_addr, 32'd0);
    chk("rst_bus_wdata", io_wdata, 32'd0);
    chk("rst_bus_wstrb", 32'(io_wstrb), 32'd0);
    chk("rst_ready_err", 32'({m1_ready, m0_ready, m1_err, m0_err}), 32'd0);
    chk("rst_rdata", m0_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 17-cycle RAM read on the default-timeout instance; the short one stays idle.
    m0_addr = 32'h4000_0010; m0_wdata = 32'h0BAD_0001; m0_wstrb = 4'b0000;
    l_valid = 1'b1;
    cyc();
    for (int k = 1; k <= 17; k++) begin
      chk("long_bus_valid", 32'(l_io_valid), 32'd1);
      chk("long_bus_addr", l_io_addr, 32'h4000_0010);
      chk("long_no_ready", 32'({l_m1_ready, l_m0_ready}), 32'd0);
      if (k == 17) begin bus_ready = 1'b1; bus_rdata = 32'h1234_5678; end
      cyc();
      bus_ready = 1'b0;
    end
    chk("long_ready", 32'(l_m0_ready), 32'd1);
    chk("long_rdata", l_m0_rdata, 32'h1234_5678);
    chk("long_err", 32'({l_m1_err, l_m0_err}), 32'd0);
    chk("long_m1_ready", 32'(l_m1_ready), 32'd0);
    chk("long_m1_rdata", l_m1_rdata, 32'h1234_5678);
    chk("long_wdata_wstrb", {l_io_wdata[27:0], l_io_wstrb}, {28'h0BAD_0001 & 28'hFFF_FFFF, 4'b0000});
    chk("long_bus_released", 32'(l_io_valid), 32'd0);
    chk("short_ignores_ready", 32'({m1_ready, m0_ready, io_valid}), 32'd0);
    l_valid = 1'b0;
    cyc();
    chk("long_ready_pulse", 32'(l_m0_ready), 32'd0);

    // Table of request patterns with hand-derived first grant and error.
    for (int i = 0; i < 8; i++) begin
      set_payload();
      run_round(vecs[i].req, vecs[i].lat_a, vecs[i].lat_b, fp, fe);
      chk("vec_first_grant", 32'(fp), 32'(vecs[i].exp_first));
      chk("vec_first_err", 32'(fe), 32'(vecs[i].exp_err));
    end

    // Port 1 write with fixed payload.
    set_payload();
    m1_addr = 32'h4000_0100; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    run_round(2'b10, 5, 0, fp, fe);
    chk("write_grant", 32'(fp), 32'd1);

    // Stray bus ready while idle.
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    chk("idle_ready_ignored", 32'({m1_ready, m0_ready, io_valid}), 32'd0);

    // Async reset in the middle of BUS.
    set_payload();
    m0_valid = 1'b1; m1_valid = 1'b1;
    cyc();
    chk("pre_reset_bus_valid", 32'(io_valid), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", 32'(io_valid), 32'd0);
    chk("reset_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
    cyc();
    chk("reset_hold_no_ready", 32'({m1_ready, m0_ready, io_valid}), 32'd0);
    rst_n = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    exp_last = 1;
    cyc();
    chk("post_reset_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
    run_round(2'b11, 2, 2, fp, fe);
    chk("post_reset_tie_port0", 32'(fp), 32'd0);

    // Random request patterns and bus latencies, including timeouts.
    for (int i = 0; i < 40; i++) begin
      set_payload();
      rq = 2'($urandom_range(1, 3));
      run_round(rq, $urandom_range(1, TO + 2), $urandom_range(1, TO + 2), fp, fe);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master arbiter and sequencer for the shared `iomem` bus that reaches main RAM (fixed-latency, ~17-cycle ready) and the memory-mapped timer. It sits between the core's instruction-fetch port and data port on one side and the single `iomem_*` master interface on the other. It grants one requester at a time (round-robin) and holds the registered request until the bus returns `iomem_ready`. It returns the registered read data, and aborts with an error response if the bus stalls past a timeout.

## Interface
- `TIMEOUT_CYCLES`, 64: max cycles `iomem_valid` may stay high without `iomem_ready` before abort; must be ≥ 2.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on timeout abort.
- `clk_i` in 1: single clock; everything is rising-edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `m0_valid_i` in 1: port 0 (data) request; held high until `m0_ready_o`.
- `m0_addr_i` in 32: port 0 byte address.
- `m0_wdata_i` in 32: port 0 write data.
- `m0_wstrb_i` in 4: port 0 byte strobes; 0 = read.
- `m0_ready_o` out 1: one-cycle completion pulse for port 0.
- `m0_rdata_o` out 32: port 0 read data, valid while `m0_ready_o`.
- `m0_err_o` out 1: high with `m0_ready_o` when the access timed out.
- `m1_valid_i`, `m1_addr_i`, `m1_wdata_i`, `m1_wstrb_i`, `m1_ready_o`, `m1_rdata_o`, `m1_err_o`: same as port 0, for port 1 (instruction fetch).
- `iomem_valid` out 1: bus request.
- `iomem_ready` in 1: bus completion.
- `iomem_addr` out 32: bus address.
- `iomem_wdata` out 32: bus write data.
- `iomem_wstrb` out 4: bus strobes.
- `iomem_rdata` in 32: bus read data, sampled when `iomem_ready`.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - If neither port is valid: stay in IDLE.
  - If exactly one port is valid: grant it.
  - If both are valid: grant the port not recorded in `last_grant`.
  - On grant: register addr/wdata/wstrb into bus registers, set `last_grant` = granted port, clear timeout counter, go to BUS.
- **BUS**
  - `iomem_valid`=1 and the bus outputs are driven from the registers, held stable for the whole state.
  - `iomem_ready`=1: capture `iomem_rdata` into the response register, err=0, go to RESP.
  - Otherwise: counter +1. If the counter reaches `TIMEOUT_CYCLES`-1 with no ready, load `ERR_RDATA` into the response register, err=1, go to RESP.
- **RESP**
  - `iomem_valid`=0.
  - The granted port's `mX_ready_o`=1, with `mX_rdata_o` = response register and `mX_err_o` = err flag. The other port's ready and err stay 0.
  - Always return to IDLE next cycle.
- The requester drops valid on the edge after ready, so no new grant is issued in RESP.
- Writes return rdata = whatever the bus drives; requesters ignore it.
- `mX_rdata_o` is driven from the response register at all times; its contents are only meaningful while ready is high.
- Request inputs are sampled only in IDLE. Address or data changes during BUS/RESP are ignored.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`; the counter does not wrap, because the timeout exits BUS first.

## Timing
- Reset (async, any state): state=IDLE, `last_grant`=1 so port 0 wins the first tie.
- Outputs in reset: `iomem_valid`=0, `iomem_addr`/`wdata`=0, `iomem_wstrb`=0, all `mX_ready_o`/`mX_err_o`=0, response register=0.
- Reset mid-BUS drops `iomem_valid` immediately, with no completion to either port.
- Latency: valid sampled in IDLE at cycle T → `iomem_valid` high from T+1.
- If `iomem_ready` arrives at cycle B, `mX_ready_o` is high at B+1 and the FSM is in IDLE at B+2.
- Total latency = bus latency + 2 cycles.
- Back-to-back on the same port: minimum 3 cycles per access (IDLE, BUS, RESP) with zero-wait bus.
- Timeout: BUS lasts exactly `TIMEOUT_CYCLES` cycles; the error response is in the following cycle.
- `iomem_ready` arriving in the same cycle as the final timeout count counts as success: ready has priority over timeout.
- `iomem_ready` seen outside BUS is ignored.

## Test plan
- **Single read, port 0.** Addr 0x4000_0010, bus ready after 17 cycles with rdata 0x1234_5678 → `m0_ready_o` 1 cycle at B+1, `m0_rdata_o`=0x1234_5678, `m0_err_o`=0, `m1_ready_o` never high.
- **Simultaneous requests, both ports held valid.** Grants alternate: first port 0, then port 1, then port 0. Each `iomem_addr` matches the granted port's address.
- **Write, port 1.** wstrb=4'b0011, addr 0x4000_0100, wdata 0xCAFE_F00D → bus shows identical addr/wdata/wstrb, stable every cycle until ready; then `m1_ready_o` pulses once.
- **Timeout.** Bus never asserts ready, `TIMEOUT_CYCLES`=8 → `iomem_valid` high exactly 8 cycles, then `m0_ready_o`=1, `m0_err_o`=1, `m0_rdata_o`=0xDEAD_BEEF, and a new request is granted afterwards.
- **Ready on last count.** `TIMEOUT_CYCLES`=8, ready in the 8th BUS cycle → normal response, err=0.
- **Async reset mid-BUS.** `rst_ni` low for 1 cycle while in BUS → `iomem_valid`=0 immediately, no ready pulses. After release, a tie grants port 0 first.
